// File: rtl/fetch_control_unit_pkg.sv
// Shared definitions for the IF-stage fetch control unit.
package fetch_control_unit_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam logic [15:0] NOP_INSTR  = 16'h0000;

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    RUN    = 3'd1,
    BFLUSH = 3'd2,
    STALL  = 3'd3,
    HALT   = 3'd4
  } fetchState_t;

endpackage

// File: rtl/fetch_control_unit_hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources in IF/ID.
module fcu_hazard_detect #(
  parameter int unsigned REG_W = 4
) (
  input  logic             idexMemRead,
  input  logic [REG_W-1:0] idexRd,
  input  logic [REG_W-1:0] ifidRs,
  input  logic [REG_W-1:0] ifidRt,
  output logic             loadUse
);

  // Register 0 is hardwired, so a load into it never creates a dependency.
  always_comb begin
    loadUse = idexMemRead && (idexRd != '0) && ((idexRd == ifidRs) || (idexRd == ifidRt));
  end

endmodule

// File: rtl/fetch_control_unit.sv
// IF-stage sequencer: PC source/write, IF/ID enable/flush and ID/EX bubble control.
module fetch_control_unit
  import fetch_control_unit_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned REG_W          = 4,
  parameter int unsigned BOOT_CYCLES    = 2,
  parameter int unsigned BRANCH_PENALTY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              idex_mem_read,
  input  logic [REG_W-1:0]  idex_rd,
  input  logic [REG_W-1:0]  ifid_rs,
  input  logic [REG_W-1:0]  ifid_rt,
  input  logic              md_busy,
  input  logic              halt,
  output logic              pc_src_sel,
  output logic [ADDR_W-1:0] branch_to_pc,
  output logic              pc_write,
  output logic              ifid_enable,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [2:0]        fetch_state,
  output logic [15:0]       stall_count
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [3:0] PEN_LOAD  = 4'(BRANCH_PENALTY - 1);

  fetchState_t       state, stateNext;
  logic [3:0]        cnt, cntNext;
  logic              pending, pendingNext;
  logic [ADDR_W-1:0] pendTarget, pendTargetNext;
  logic              loadUse;
  logic              takeBranch;
  logic [ADDR_W-1:0] takeTarget;

  fcu_hazard_detect #(
    .REG_W(REG_W)
  ) uHazard (
    .idexMemRead(idex_mem_read),
    .idexRd     (idex_rd),
    .ifidRs     (ifid_rs),
    .ifidRt     (ifid_rt),
    .loadUse    (loadUse)
  );

  assign fetch_state = state;

  // State, shared boot/penalty counter and deferred-branch registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= BOOT;
      cnt        <= '0;
      pending    <= 1'b0;
      pendTarget <= '0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      pending    <= pendingNext;
      pendTarget <= pendTargetNext;
    end
  end

  // Next state and zero-latency control outputs.
  always_comb begin
    stateNext      = state;
    cntNext        = cnt;
    pendingNext    = pending;
    pendTargetNext = pendTarget;
    takeBranch     = 1'b0;
    takeTarget     = branch_target;
    pc_src_sel     = 1'b0;
    branch_to_pc   = '0;
    pc_write       = 1'b0;
    ifid_enable    = 1'b0;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;

    case (state)
      BOOT: begin
        ifid_flush = 1'b1;
        if (cnt == BOOT_LAST) begin
          stateNext = RUN;
          cntNext   = '0;
        end else begin
          cntNext = cnt + 4'd1;
        end
      end
      RUN: begin
        if (halt) begin
          ifid_flush = 1'b1;
          stateNext  = HALT;
        end else if (branch_taken) begin
          takeBranch = 1'b1;
        end else if (loadUse) begin
          idex_bubble = 1'b1;
        end else if (md_busy) begin
          stateNext = STALL;
        end else begin
          pc_write    = 1'b1;
          ifid_enable = 1'b1;
        end
      end
      BFLUSH: begin
        pc_write   = 1'b1;
        ifid_flush = 1'b1;
        cntNext    = cnt - 4'd1;
        if (cnt <= 4'd1) stateNext = RUN;
      end
      STALL: begin
        if (md_busy) begin
          if (branch_taken) begin
            pendingNext    = 1'b1;
            pendTargetNext = branch_target;
          end
        end else begin
          // A branch resolving on the release cycle is newer than any latched one.
          pendingNext = 1'b0;
          stateNext   = RUN;
          if (branch_taken) begin
            takeBranch = 1'b1;
          end else if (pending) begin
            takeBranch = 1'b1;
            takeTarget = pendTarget;
          end else begin
            pc_write    = 1'b1;
            ifid_enable = 1'b1;
          end
        end
      end
      HALT: begin
        ifid_flush = 1'b1;
      end
      default: begin
        ifid_flush = 1'b1;
        stateNext  = BOOT;
      end
    endcase

    if (takeBranch) begin
      pc_src_sel   = 1'b1;
      branch_to_pc = takeTarget;
      pc_write     = 1'b1;
      ifid_flush   = 1'b1;
      if (BRANCH_PENALTY > 1) begin
        stateNext = BFLUSH;
        cntNext   = PEN_LOAD;
      end else begin
        stateNext = RUN;
      end
    end
  end

  // Saturating count of post-boot cycles in which the PC did not advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if ((state != BOOT) && !pc_write && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_control_unit.sv
// Testbench for fetch_control_unit: two parameterisations against a phase-based reference model.
module tb_fetch_control_unit;

  typedef struct packed {
    logic        pcSrc;
    logic [15:0] tgt;
    logic        pcWr;
    logic        ifEn;
    logic        ifFl;
    logic        bub;
    logic [2:0]  st;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_taken, idex_mem_read, md_busy, halt;
  logic [15:0] branch_target;
  logic [3:0]  idex_rd, ifid_rs, ifid_rt;

  logic        pcSrc[2];
  logic [15:0] btp[2];
  logic        pcWr[2], ifEn[2], ifFl[2], bub[2];
  logic [2:0]  fst[2];
  logic [15:0] scnt[2];

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  fetch_control_unit #(.ADDR_W(16), .REG_W(4), .BOOT_CYCLES(2), .BRANCH_PENALTY(1)) dutA (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_target(branch_target),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .md_busy(md_busy), .halt(halt), .pc_src_sel(pcSrc[0]), .branch_to_pc(btp[0]),
    .pc_write(pcWr[0]), .ifid_enable(ifEn[0]), .ifid_flush(ifFl[0]), .idex_bubble(bub[0]),
    .fetch_state(fst[0]), .stall_count(scnt[0])
  );

  fetch_control_unit #(.ADDR_W(16), .REG_W(4), .BOOT_CYCLES(3), .BRANCH_PENALTY(2)) dutB (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_target(branch_target),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .md_busy(md_busy), .halt(halt), .pc_src_sel(pcSrc[1]), .branch_to_pc(btp[1]),
    .pc_write(pcWr[1]), .ifid_enable(ifEn[1]), .ifid_flush(ifFl[1]), .idex_bubble(bub[1]),
    .fetch_state(fst[1]), .stall_count(scnt[1])
  );

  // Reference model: remaining boot/flush cycles, frozen/halted flags, deferred target.
  int          bootCyc[2] = '{2, 3};
  int          pen[2]     = '{1, 2};
  int          bootLeft[2], flushLeft[2], stalls[2];
  bit          frozen[2], halted[2], pend[2];
  logic [15:0] pendTgt[2];

  function automatic bit loadUseNow();
    return idex_mem_read && (idex_rd != 4'd0) && ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));
  endfunction

  function automatic outs_t expOut(int i);
    outs_t e;
    e = '0;
    if (halted[i]) begin
      e.ifFl = 1'b1; e.st = 3'd4;
    end else if (bootLeft[i] > 0) begin
      e.ifFl = 1'b1; e.st = 3'd0;
    end else if (flushLeft[i] > 0) begin
      e.pcWr = 1'b1; e.ifFl = 1'b1; e.st = 3'd2;
    end else if (frozen[i]) begin
      e.st = 3'd3;
      if (!md_busy) begin
        if (branch_taken || pend[i]) begin
          e.pcSrc = 1'b1; e.pcWr = 1'b1; e.ifFl = 1'b1;
          e.tgt = branch_taken ? branch_target : pendTgt[i];
        end else begin
          e.pcWr = 1'b1; e.ifEn = 1'b1;
        end
      end
    end else begin
      e.st = 3'd1;
      if (halt) e.ifFl = 1'b1;
      else if (branch_taken) begin
        e.pcSrc = 1'b1; e.pcWr = 1'b1; e.ifFl = 1'b1; e.tgt = branch_target;
      end else if (loadUseNow()) e.bub = 1'b1;
      else if (!md_busy) begin
        e.pcWr = 1'b1; e.ifEn = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic outs_t act(int i);
    return {pcSrc[i], btp[i], pcWr[i], ifEn[i], ifFl[i], bub[i], fst[i]};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      bootLeft[i] = bootCyc[i]; flushLeft[i] = 0; stalls[i] = 0;
      frozen[i] = 0; halted[i] = 0; pend[i] = 0; pendTgt[i] = '0;
    end
  endtask

  task automatic advance(int i);
    outs_t e;
    e = expOut(i);
    if (!halted[i] && bootLeft[i] == 0 && !e.pcWr && stalls[i] < 65535) stalls[i]++;
    if (halted[i]) begin
    end else if (bootLeft[i] > 0) bootLeft[i]--;
    else if (flushLeft[i] > 0) flushLeft[i]--;
    else if (frozen[i]) begin
      if (md_busy) begin
        if (branch_taken) begin pend[i] = 1; pendTgt[i] = branch_target; end
      end else begin
        if (branch_taken || pend[i]) flushLeft[i] = pen[i] - 1;
        frozen[i] = 0; pend[i] = 0;
      end
    end else begin
      if (halt) halted[i] = 1;
      else if (branch_taken) flushLeft[i] = pen[i] - 1;
      else if (loadUseNow()) begin end
      else if (md_busy) frozen[i] = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) modelReset();
    else for (int i = 0; i < 2; i++) advance(i);
    @(negedge clk);
  endtask

  task automatic setIdle();
    branch_taken = 0; branch_target = '0; idex_mem_read = 0; idex_rd = '0;
    ifid_rs = '0; ifid_rt = '0; md_busy = 0; halt = 0;
  endtask

  task automatic test_reset();
    outs_t r;
    r = '0; r.ifFl = 1'b1;
    setIdle();
    #1 rst = 0;
    modelReset();
    @(negedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      nTests++;
      if (act(i) !== r || scnt[i] !== 16'd0) begin
        nFail++; $display("FAIL reset_values inst%0d: got %h cnt %h expected %h cnt 0", i, act(i), scnt[i], r);
      end
    end
    @(negedge clk);
    rst = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      nTests++;
      if (pcWr[0] !== (k >= 2)) begin
        nFail++; $display("FAIL boot_pc_write cycle%0d: got %b expected %b", k, pcWr[0], k >= 2);
      end
      for (int i = 0; i < 2; i++) begin
        nTests++;
        if (act(i) !== expOut(i) || scnt[i] !== 16'd0) begin
          nFail++; $display("FAIL boot_model inst%0d cycle%0d: got %h cnt %h expected %h cnt 0", i, k, act(i), scnt[i], expOut(i));
        end
      end
      tick();
    end
  endtask

  task automatic test_branch();
    branch_taken = 1; branch_target = 16'h0040;
    #1;
    for (int i = 0; i < 2; i++) begin
      nTests++;
      if (pcSrc[i] !== 1'b1 || btp[i] !== 16'h0040 || ifFl[i] !== 1'b1 || pcWr[i] !== 1'b1) begin
        nFail++; $display("FAIL branch_same_cycle inst%0d: got %h expected pcSrc=1 tgt=0040 flush=1 pcWr=1", i, act(i));
      end
    end
    tick();
    branch_taken = 0;
    #1;
    nTests++;
    if (pcSrc[0] !== 1'b0 || ifFl[0] !== 1'b0 || pcWr[0] !== 1'b1) begin
      nFail++; $display("FAIL branch_pen1_after: got %h expected normal fetch", act(0));
    end
    nTests++;
    if (fst[1] !== 3'd2 || ifFl[1] !== 1'b1 || pcSrc[1] !== 1'b0 || pcWr[1] !== 1'b1) begin
      nFail++; $display("FAIL branch_pen2_flush: got %h expected BFLUSH flush=1 pcSrc=0 pcWr=1", act(1));
    end
    tick();
    #1;
    nTests++;
    if (fst[1] !== 3'd1 || ifFl[1] !== 1'b0) begin
      nFail++; $display("FAIL branch_pen2_return: got %h expected RUN no flush", act(1));
    end
    tick();
  endtask

  task automatic test_load_use();
    idex_mem_read = 1; idex_rd = 4'd3; ifid_rt = 4'd3; ifid_rs = 4'd5;
    #1;
    for (int i = 0; i < 2; i++) begin
      nTests++;
      if (pcWr[i] !== 1'b0 || bub[i] !== 1'b1 || ifEn[i] !== 1'b0) begin
        nFail++; $display("FAIL load_use_stall inst%0d: got %h expected pcWr=0 bubble=1 en=0", i, act(i));
      end
    end
    tick();
    idex_rd = 4'd0; ifid_rt = 4'd0; ifid_rs = 4'd0;
    #1;
    for (int i = 0; i < 2; i++) begin
      nTests++;
      if (pcWr[i] !== 1'b1 || bub[i] !== 1'b0 || scnt[i] !== 16'(stalls[i])) begin
        nFail++; $display("FAIL load_use_r0 inst%0d: got %h cnt %h expected pcWr=1 bubble=0 cnt %h", i, act(i), scnt[i], 16'(stalls[i]));
      end
    end
    tick();
    setIdle();
  endtask

  task automatic test_md_busy_branch();
    int base[2];
    for (int i = 0; i < 2; i++) base[i] = stalls[i];
    md_busy = 1; branch_target = 16'h0100;
    for (int c = 0; c < 4; c++) begin
      branch_taken = (c == 1);
      #1;
      for (int i = 0; i < 2; i++) begin
        nTests++;
        if (pcWr[i] !== 1'b0 || ifEn[i] !== 1'b0 || (c > 0 && fst[i] !== 3'd3)) begin
          nFail++; $display("FAIL md_freeze inst%0d cycle%0d: got %h expected frozen", i, c, act(i));
        end
      end
      tick();
    end
    md_busy = 0; branch_taken = 0; branch_target = 16'hBEEF;
    #1;
    for (int i = 0; i < 2; i++) begin
      nTests++;
      if (pcSrc[i] !== 1'b1 || btp[i] !== 16'h0100 || pcWr[i] !== 1'b1 || scnt[i] !== 16'(base[i] + 4)) begin
        nFail++; $display("FAIL md_pending_branch inst%0d: got %h cnt %h expected pcSrc=1 tgt=0100 pcWr=1 cnt %h", i, act(i), scnt[i], 16'(base[i] + 4));
      end
    end
    tick();
    setIdle();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    outs_t r;
    r = '0; r.ifFl = 1'b1;
    md_busy = 1;
    tick();
    branch_taken = 1; branch_target = 16'h0200;
    tick();
    branch_taken = 0;
    #2 rst = 0;
    modelReset();
    #1;
    for (int i = 0; i < 2; i++) begin
      nTests++;
      if (act(i) !== r || scnt[i] !== 16'd0) begin
        nFail++; $display("FAIL async_reset_stall inst%0d: got %h cnt %h expected %h cnt 0", i, act(i), scnt[i], r);
      end
    end
    tick();
    rst = 1; md_busy = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        nTests++;
        if (pcSrc[i] !== 1'b0 || act(i) !== expOut(i)) begin
          nFail++; $display("FAIL no_branch_after_reset inst%0d cycle%0d: got %h expected %h", i, k, act(i), expOut(i));
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 7) == 0) md_busy = ~md_busy;
      branch_taken  = ($urandom_range(0, 5) == 0);
      branch_target = 16'($urandom);
      idex_mem_read = ($urandom_range(0, 2) == 0);
      idex_rd       = 4'($urandom_range(0, 3));
      ifid_rs       = 4'($urandom_range(0, 3));
      ifid_rt       = 4'($urandom_range(0, 3));
      #1;
      for (int i = 0; i < 2; i++) begin
        nTests++;
        if (act(i) !== expOut(i) || scnt[i] !== 16'(stalls[i])) begin
          nFail++; $display("FAIL random inst%0d step%0d: got %h cnt %h expected %h cnt %h", i, n, act(i), scnt[i], expOut(i), 16'(stalls[i]));
        end
      end
      tick();
    end
    setIdle();
    repeat (3) tick();
  endtask

  task automatic test_halt();
    halt = 1; branch_taken = 1; branch_target = 16'h1234;
    #1;
    for (int i = 0; i < 2; i++) begin
      nTests++;
      if (fst[i] !== 3'd1 || pcWr[i] !== 1'b0 || ifFl[i] !== 1'b1 || pcSrc[i] !== 1'b0) begin
        nFail++; $display("FAIL halt_over_branch inst%0d: got %h expected RUN pcWr=0 flush=1 pcSrc=0", i, act(i));
      end
    end
    tick();
    halt = 0;
    for (int k = 0; k < 5; k++) begin
      branch_taken = 1'($urandom_range(0, 1));
      md_busy      = 1'($urandom_range(0, 1));
      #1;
      for (int i = 0; i < 2; i++) begin
        nTests++;
        if (fst[i] !== 3'd4 || pcWr[i] !== 1'b0 || ifFl[i] !== 1'b1) begin
          nFail++; $display("FAIL halt_hold inst%0d cycle%0d: got %h expected HALT pcWr=0", i, k, act(i));
        end
      end
      tick();
    end
    setIdle();
    repeat (65540) tick();
    #1;
    for (int i = 0; i < 2; i++) begin
      nTests++;
      if (scnt[i] !== 16'hFFFF || pcWr[i] !== 1'b0 || fst[i] !== 3'd4) begin
        nFail++; $display("FAIL stall_saturate inst%0d: got cnt %h state %0d expected cnt ffff state 4", i, scnt[i], fst[i]);
      end
    end
    rst = 0;
    modelReset();
    #1;
    for (int i = 0; i < 2; i++) begin
      nTests++;
      if (fst[i] !== 3'd0 || scnt[i] !== 16'd0) begin
        nFail++; $display("FAIL halt_reset_exit inst%0d: got state %0d cnt %h expected 0 0", i, fst[i], scnt[i]);
      end
    end
    tick();
    rst = 1;
    repeat (4) tick();
    #1;
    for (int i = 0; i < 2; i++) begin
      nTests++;
      if (fst[i] !== 3'd1 || act(i) !== expOut(i)) begin
        nFail++; $display("FAIL halt_reboot inst%0d: got %h expected %h", i, act(i), expOut(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_load_use();
    test_md_busy_branch();
    test_reset_mid_stall();
    test_random();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #5_000_000;
    nFail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $fatal(1);
  end

endmodule
